// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory arbiter: FSM state encoding and
// the default memory latency.
package mem_arbiter_pkg;

  localparam int MEM_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DM_BUSY = 2'd2,
    ST_IF_DROP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter that times one memory access: loaded with MEM_LAT-1 at grant,
// decremented while the access is in flight, flags zero on the final cycle.
module mem_lat_counter #(
  parameter int MEM_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MEM_LAT - 1);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between instruction fetch
// and data access, with data priority, flush-aware fetch and stall outputs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state, state_nxt;
  logic              grant_if, grant_dm;
  logic              if_done_set, dm_done_set;
  logic              if_done_q, dm_done_q;
  logic              acc_wr;
  logic              cnt_zero;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant_if | grant_dm),
    .dec   (state != ST_IDLE),
    .zero  (cnt_zero)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt   = state;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    if_done_set = 1'b0;
    dm_done_set = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A requester still high during its own done cycle is not a new request.
        if (dm_req && !dm_done_q) begin
          grant_dm  = 1'b1;
          state_nxt = ST_DM_BUSY;
        end else if (if_req && !if_done_q && !if_flush) begin
          grant_if  = 1'b1;
          state_nxt = ST_IF_BUSY;
        end
      end
      ST_IF_BUSY: begin
        if (cnt_zero) begin
          if_done_set = !if_flush;
          state_nxt   = ST_IDLE;
        end else if (if_flush) begin
          state_nxt = ST_IF_DROP;
        end
      end
      ST_IF_DROP: begin
        if (cnt_zero) state_nxt = ST_IDLE;
      end
      ST_DM_BUSY: begin
        if (cnt_zero) begin
          dm_done_set = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      acc_wr     <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state     <= state_nxt;
      mem_en    <= grant_if | grant_dm;
      mem_wr    <= grant_dm & dm_wr;
      if_done_q <= if_done_set;
      dm_done_q <= dm_done_set;
      if (grant_dm) begin
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        acc_wr    <= dm_wr;
      end else if (grant_if) begin
        mem_addr <= if_addr;
        acc_wr   <= 1'b0;
      end
      if (if_done)             if_rdata_q <= mem_rdata;
      if (dm_done_q && !acc_wr) dm_rdata_q <= mem_rdata;
    end
  end

  // Memory data is valid only in the done cycle, so it is forwarded straight
  // through then and the captured copy is held afterwards.
  assign if_done  = if_done_q & ~if_flush;
  assign dm_done  = dm_done_q;
  assign if_rdata = if_done ? mem_rdata : if_rdata_q;
  assign dm_rdata = (dm_done_q && !acc_wr) ? mem_rdata : dm_rdata_q;
  assign stall_if = if_req & ~if_done;
  assign stall_dm = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=4 instance and a MEM_LAT=1
// instance, each served by a latency-matched memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  // MEM_LAT=4 instance signals
  logic        if_req = 1'b0, if_flush = 1'b0, if_done;
  logic [15:0] if_addr = '0, if_rdata;
  logic        dm_req = 1'b0, dm_wr = 1'b0, dm_done;
  logic [15:0] dm_addr = '0, dm_wdata = '0, dm_rdata;
  logic        stall_if, stall_dm, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  // MEM_LAT=1 instance signals
  logic        if_req_b = 1'b0, if_flush_b = 1'b0, if_done_b;
  logic [15:0] if_addr_b = '0, if_rdata_b;
  logic        dm_req_b = 1'b0, dm_wr_b = 1'b0, dm_done_b;
  logic [15:0] dm_addr_b = '0, dm_wdata_b = '0, dm_rdata_b;
  logic        stall_if_b, stall_dm_b, mem_en_b, mem_wr_b;
  logic [15:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_flush(if_flush_b),
    .if_rdata(if_rdata_b), .if_done(if_done_b),
    .dm_req(dm_req_b), .dm_wr(dm_wr_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
    .dm_rdata(dm_rdata_b), .dm_done(dm_done_b),
    .stall_if(stall_if_b), .stall_dm(stall_dm_b),
    .mem_en(mem_en_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed function of the address; 0xDEAD when no read is due.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hA5B5;
  endfunction

  logic [3:0]  pv = '0;
  logic [15:0] pd [4];
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en & ~mem_wr};
    pd[0] <= mem_fn(mem_addr);
    for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
  end
  assign mem_rdata = pv[3] ? pd[3] : 16'hDEAD;

  logic        pv_b = 1'b0;
  logic [15:0] pd_b = '0;
  always @(posedge clk) begin
    pv_b <= mem_en_b & ~mem_wr_b;
    pd_b <= mem_fn(mem_addr_b);
  end
  assign mem_rdata_b = pv_b ? pd_b : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_done", if_done, 0);
    check("rst_dm_done", dm_done, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // 1: single fetch
    if_req = 1'b1; if_addr = 16'h0010;
    #1 check("t1_stall_req", stall_if, 1);
    cyc();
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_addr", mem_addr, 16'h0010);
    check("t1_mem_wr", mem_wr, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("t1_mem_en_off", mem_en, 0);
      check("t1_no_done", if_done, 0);
      check("t1_stall", stall_if, 1);
    end
    cyc();
    check("t1_done", if_done, 1);
    check("t1_rdata", if_rdata, 16'hA5A5);
    check("t1_stall_done", stall_if, 0);
    if_req = 1'b0;
    cyc();
    check("t1_done_pulse", if_done, 0);
    check("t1_rdata_hold", if_rdata, 16'hA5A5);

    // 2: simultaneous requests, data wins
    if_req = 1'b1; if_addr = 16'h0020;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0200;
    cyc();
    check("t2_dm_grant", mem_en, 1);
    check("t2_dm_addr", mem_addr, 16'h0200);
    cyc(4);
    check("t2_dm_done", dm_done, 1);
    check("t2_dm_rdata", dm_rdata, 16'hA7B5);
    check("t2_if_waiting", stall_if, 1);
    check("t2_turnaround", mem_en, 0);
    dm_req = 1'b0;
    cyc();
    check("t2_if_grant", mem_en, 1);
    check("t2_if_addr", mem_addr, 16'h0020);
    cyc(3);
    check("t2_if_not_yet", if_done, 0);
    cyc();
    check("t2_if_done", if_done, 1);
    check("t2_if_rdata", if_rdata, 16'hA595);
    check("t2_dm_rdata_hold", dm_rdata, 16'hA7B5);
    if_req = 1'b0;
    cyc();

    // 3: store
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'h1234;
    cyc();
    check("t3_mem_en", mem_en, 1);
    check("t3_mem_wr", mem_wr, 1);
    check("t3_mem_wdata", mem_wdata, 16'h1234);
    check("t3_mem_addr", mem_addr, 16'h0300);
    cyc(3);
    check("t3_stall", stall_dm, 1);
    cyc();
    check("t3_done", dm_done, 1);
    check("t3_rdata_unch", dm_rdata, 16'hA7B5);
    check("t3_stall_done", stall_dm, 0);
    dm_req = 1'b0; dm_wr = 1'b0;
    cyc();

    // 4: fetch flushed mid-flight, then refetch
    if_req = 1'b1; if_addr = 16'h0040;
    cyc();
    check("t4_grant", mem_en, 1);
    cyc(2);
    if_flush = 1'b1;
    cyc();
    if_flush = 1'b0; if_addr = 16'h0080;
    check("t4_no_done_a", if_done, 0);
    cyc();
    check("t4_no_done_b", if_done, 0);
    check("t4_rdata_unch", if_rdata, 16'hA595);
    check("t4_idle_no_en", mem_en, 0);
    cyc();
    check("t4_regrant", mem_en, 1);
    check("t4_regrant_addr", mem_addr, 16'h0080);
    cyc(4);
    check("t4_done", if_done, 1);
    check("t4_rdata", if_rdata, 16'hA535);
    if_req = 1'b0;
    cyc();

    // flush in IDLE blocks fetch grant; flush in the done cycle hides if_done
    if_req = 1'b1; if_addr = 16'h0100; if_flush = 1'b1;
    cyc();
    check("fl_idle_block", mem_en, 0);
    if_flush = 1'b0;
    cyc();
    check("fl_idle_grant", mem_en, 1);
    check("fl_idle_addr", mem_addr, 16'h0100);
    cyc(4);
    if_flush = 1'b1;
    #1 check("fl_done_supp", if_done, 0);
    check("fl_done_rdata", if_rdata, 16'hA535);
    if_req = 1'b0;
    cyc();
    if_flush = 1'b0;
    check("fl_rdata_hold", if_rdata, 16'hA535);
    check("fl_no_done", if_done, 0);

    // 5: reset during DM_BUSY; flush does not block or disturb data
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0500; if_flush = 1'b1;
    cyc();
    check("t5_dm_grant_flush", mem_en, 1);
    check("t5_addr", mem_addr, 16'h0500);
    cyc();
    if_flush = 1'b0;
    cyc();
    rst_n = 1'b0; dm_req = 1'b0;
    #1;
    check("t5_rst_mem_en", mem_en, 0);
    check("t5_rst_mem_wr", mem_wr, 0);
    check("t5_rst_mem_addr", mem_addr, 0);
    check("t5_rst_mem_wdata", mem_wdata, 0);
    check("t5_rst_dm_rdata", dm_rdata, 0);
    check("t5_rst_if_rdata", if_rdata, 0);
    check("t5_rst_dm_done", dm_done, 0);
    check("t5_rst_stall_dm", stall_dm, 0);
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("t5_no_late_done", dm_done, 0);
      check("t5_no_issue", mem_en, 0);
    end
    dm_req = 1'b1;
    cyc();
    check("t5_regrant", mem_en, 1);
    check("t5_regrant_addr", mem_addr, 16'h0500);
    cyc(4);
    check("t5_done", dm_done, 1);
    check("t5_rdata", dm_rdata, 16'hA0B5);
    dm_req = 1'b0;
    cyc();

    // 6: MEM_LAT=1, alternating data/fetch, grant every 2 cycles
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a;
      a = 16'h0600 + 16'(i * 16);
      if (i % 2 == 0) begin
        dm_req_b = 1'b1; dm_addr_b = a;
      end else begin
        if_req_b = 1'b1; if_addr_b = a;
      end
      cyc();
      check("t6_grant", mem_en_b, 1);
      check("t6_addr", mem_addr_b, a);
      cyc();
      check("t6_en_off", mem_en_b, 0);
      if (i % 2 == 0) begin
        check("t6_dm_done", dm_done_b, 1);
        check("t6_dm_rdata", dm_rdata_b, mem_fn(a));
        dm_req_b = 1'b0;
      end else begin
        check("t6_if_done", if_done_b, 1);
        check("t6_if_rdata", if_rdata_b, mem_fn(a));
        if_req_b = 1'b0;
      end
    end
    cyc();
    check("t6_idle", mem_en_b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
